// File: rtl/key_pkg.sv
// key_debounce shared types and helpers.
// FSM state encoding and ms-to-cycle conversion.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    RELEASE_DB
  } key_state_t;

  function automatic int unsigned ms_to_cycles(
    input int unsigned freq_hz,
    input int unsigned ms
  );
    return freq_hz / 32'd1000 * ms;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous bit.
// Flops reset to RST_VAL so no false edge follows reset.
module sync_2ff #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  // Shift the raw bit through two flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/key_debounce.sv
// Push-button debouncer with press/release/long-press events.
// Long-press timing is built only with KEY_DEBOUNCE_LONG_EN.
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ   = 50_000_000,
  parameter int unsigned DEBOUNCE_MS   = 20,
  parameter int unsigned LONG_PRESS_MS = 1000,
  parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int unsigned DB_CNT =
    ms_to_cycles(CLK_FREQ_HZ, DEBOUNCE_MS);
  localparam int DBW = $clog2(DB_CNT);
  localparam logic [DBW-1:0] DB_TERM = DBW'(DB_CNT - 1);

  if (DB_CNT < 2) begin : g_bad_db
    $error("key_debounce: DB_CNT must be >= 2");
  end

  logic key_s;
  logic pk;

  sync_2ff #(
    .RST_VAL(KEY_ACTIVE_LOW)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d_i(key_in),
    .q_o(key_s)
  );

  assign pk = KEY_ACTIVE_LOW ? ~key_s : key_s;

  key_state_t     state_q, state_d;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic           level_q, level_d;
  logic           press_q, press_d;
  logic           rel_q, rel_d;

  // State, debounce counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      db_cnt_q <= '0;
      level_q  <= 1'b0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      db_cnt_q <= db_cnt_d;
      level_q  <= level_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
    end
  end

  // Next state: a level must be stable for DB_CNT cycles to be taken.
  always_comb begin
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    press_d  = 1'b0;
    rel_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pk) begin
          state_d  = PRESS_DB;
          db_cnt_d = '0;
        end
      end
      PRESS_DB: begin
        if (!pk) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_TERM) begin
          state_d = HELD;
          press_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!pk) begin
          state_d  = RELEASE_DB;
          db_cnt_d = '0;
        end
      end
      RELEASE_DB: begin
        if (pk) begin
          state_d = HELD;
        end else if (db_cnt_q == DB_TERM) begin
          state_d = IDLE;
          rel_d   = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        db_cnt_d = '0;
      end
    endcase
    level_d = (state_d == HELD) || (state_d == RELEASE_DB);
  end

  assign key_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;

`ifdef KEY_DEBOUNCE_LONG_EN
  localparam int unsigned LONG_CNT =
    ms_to_cycles(CLK_FREQ_HZ, LONG_PRESS_MS);
  localparam int unsigned HSAT = LONG_CNT - DB_CNT;
  localparam int HW = $clog2(HSAT + 1);
  localparam logic [HW-1:0] H_TERM = HW'(HSAT - 1);
  localparam logic [HW-1:0] H_SAT  = HW'(HSAT);

  if (LONG_CNT <= DB_CNT) begin : g_bad_long
    $error("key_debounce: LONG_CNT must exceed DB_CNT");
  end

  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          long_q, long_d;

  // Hold timer and long-press event register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_q <= '0;
      long_q     <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      long_q     <= long_d;
    end
  end

  // Count HELD cycles; fire once at the terminal, then stick at H_SAT.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    long_d     = 1'b0;
    if (state_q == PRESS_DB && state_d == HELD) begin
      hold_cnt_d = '0;
    end else if (state_q == HELD) begin
      if (hold_cnt_q == H_TERM) begin
        long_d     = 1'b1;
        hold_cnt_d = H_SAT;
      end else if (hold_cnt_q != H_SAT) begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end
    end
  end

  assign long_pulse = long_q;
`else
  logic unused_long;
  assign unused_long = ^LONG_PRESS_MS;
  assign long_pulse  = 1'b0;
`endif

endmodule
